vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameters (name, default, meaning), each SHALL be overridable:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch
REQ-002 Ports (name, direction, width, meaning):
- VGA_clk, in, 1, pixel clock, the block's only clock
- reset, in, 1, asynchronous active-high reset
- xCount, out, 10, current pixel column
- yCount, out, 10, current line
- hsync, out, 1, horizontal sync, active low
- vsync, out, 1, vertical sync, active low
- displayArea, out, 1, current pixel is visible
- line_tick, out, 1, last pixel of the line
- frame_tick, out, 1, first pixel of vertical blanking
- vphase, out, 2, vertical phase state
- frame_count, out, 16, frames completed
REQ-003 Only one clock (VGA_clk) SHALL be used; reset SHALL be asynchronous and active-high.

Function
REQ-004 xCount SHALL step 0 to H_TOTAL-1 (H_TOTAL = sum of the H_* parameters, 800 by default), one step per VGA_clk rising edge, then wrap to 0.
REQ-005 yCount SHALL increment only on the xCount wrap and SHALL wrap from V_TOTAL-1 (525 by default) to 0.
REQ-006 All outputs SHALL be registered and coherent: every output SHALL describe the (xCount, yCount) it is presented with, with zero relative skew.
REQ-007 hsync SHALL be 0 iff H_ACTIVE+H_FP <= xCount < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
REQ-008 vsync SHALL be 0 iff V_ACTIVE+V_FP <= yCount < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
REQ-009 displayArea SHALL be 1 iff xCount < H_ACTIVE and yCount < V_ACTIVE.
REQ-010 line_tick SHALL be 1 for exactly the cycle where xCount == H_TOTAL-1.
REQ-011 frame_tick SHALL be 1 for exactly the cycle where (xCount, yCount) == (0, V_ACTIVE).
REQ-012 The vphase FSM SHALL have states V_ACT=0, V_FRONT=1, V_SYNCP=2, V_BACK=3.
REQ-013 vphase SHALL change only on the line wrap, in the order ACT->FRONT->SYNCP->BACK->ACT, at the yCount values V_ACTIVE, V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC and 0 respectively.
REQ-014 On the simultaneous x and y wrap at (H_TOTAL-1, V_TOTAL-1), the next cycle SHALL present (0, 0) with vphase=V_ACT and displayArea=1.

Reset
REQ-015 While reset=1 the outputs SHALL be held at: xCount=0, yCount=0, hsync=1, vsync=1, displayArea=1, line_tick=0, frame_tick=0, vphase=V_ACT, frame_count=0.
REQ-016 Reset asserted mid-line or mid-frame SHALL force the REQ-015 values immediately, with no clock edge required.
REQ-017 The first rising edge after reset release SHALL present xCount=1, yCount=0.

Configuration
REQ-018 With VGA_FRAME_CNT_EN defined, frame_count SHALL increment on the cycle after frame_tick and wrap from 65535 to 0.
REQ-019 Without VGA_FRAME_CNT_EN, frame_count SHALL be the constant 0, and the 16-bit counter SHALL NOT be built.

Structure
REQ-020 Package vga_timing_pkg SHALL hold the 640x480 timing constants, the H_TOTAL and V_TOTAL derivations, and the vphase enum typedef.
REQ-021 One sub-module, vga_mod_counter (parameterised modulus, enable input, count output, terminal-count output), SHALL be instantiated twice, once for x and once for y.

Verification
REQ-022 Release reset and run 800 clocks -> xCount runs 0..799 then returns to 0, and yCount goes from 0 to 1 on the wrap.
REQ-023 Scan line 0 -> hsync=0 exactly for xCount 656..751, and line_tick=1 only at xCount=799.
REQ-024 Run a full frame -> vsync=0 only for yCount 490..491, frame_tick=1 once at (0,480), vphase sequence 0,1,2,3,0 at yCount 480,490,492,0, and displayArea=1 for 307200 cycles.
REQ-025 Assert reset at (400,300) -> outputs take the REQ-015 values asynchronously, and the first edge after release gives (1,0).
REQ-026 With VGA_FRAME_CNT_EN defined, preload frame_count to 65535 and cross frame_tick -> frame_count=0; without the macro, frame_count stays 0 over 3 frames.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing: 640x480@60 default constants, derived totals,
// the vertical phase encoding and a small window-decode helper.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Vertical phase of the frame; the numeric values are visible on the vphase port
    typedef enum logic [1:0] {
        V_ACT   = 2'd0,
        V_FRONT = 2'd1,
        V_SYNCP = 2'd2,
        V_BACK  = 2'd3
    } vphase_t;

    // True when pos lies in the half-open window [start, start+len)
    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-N up counter with enable and a terminal-count flag.
// Used once for the pixel column and once for the line number.
module vga_mod_counter #(
    parameter int MODULUS = 800,
    parameter int WIDTH   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    assign tc = (count == LAST);

    // Advance on enable, wrapping from the last value back to zero
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is always written with non-blocking assignments
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: column/line counters plus registered sync, blanking,
// tick and vertical-phase outputs that all describe the presented (x, y).
// Optional feature: define VGA_FRAME_CNT_EN to build the 16-bit frame counter;
// otherwise frame_count is tied to zero.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic        VGA_clk,
    input  logic        reset,
    output logic [9:0]  xCount,
    output logic [9:0]  yCount,
    output logic        hsync,
    output logic        vsync,
    output logic        displayArea,
    output logic        line_tick,
    output logic        frame_tick,
    output logic [1:0]  vphase,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic       x_tc;
    logic       y_tc;
    logic [9:0] x_next;
    logic [9:0] y_next;
    vphase_t    vphase_q;

    vga_mod_counter #(.MODULUS(H_TOTAL), .WIDTH(10)) u_x_cnt (
        .clk   (VGA_clk),
        .rst   (reset),
        .en    (1'b1),
        .count (xCount),
        .tc    (x_tc)
    );

    vga_mod_counter #(.MODULUS(V_TOTAL), .WIDTH(10)) u_y_cnt (
        .clk   (VGA_clk),
        .rst   (reset),
        .en    (x_tc),
        .count (yCount),
        .tc    (y_tc)
    );

    // Position the counters will hold after the next edge; decoding this
    // lets every registered flag line up with the counters without skew
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred
        x_next = xCount + 10'd1;
        y_next = yCount;
        if (x_tc) begin
            x_next = '0;
            y_next = y_tc ? '0 : yCount + 10'd1;
        end
    end

    // Registered sync, visibility and tick decodes of the upcoming position
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            displayArea <= 1'b1;
            line_tick   <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            hsync       <= !in_window(int'(x_next), H_ACTIVE + H_FP, H_SYNC);
            vsync       <= !in_window(int'(y_next), V_ACTIVE + V_FP, V_SYNC);
            displayArea <= (int'(x_next) < H_ACTIVE) && (int'(y_next) < V_ACTIVE);
            line_tick   <= (int'(x_next) == H_TOTAL - 1);
            frame_tick  <= (x_next == 10'd0) && (int'(y_next) == V_ACTIVE);
        end
    end

    // Vertical phase FSM: steps only on the line wrap, keyed on the new line number
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            vphase_q <= V_ACT;
        end else if (x_tc) begin
            case (vphase_q)
                V_ACT:   if (int'(y_next) == V_ACTIVE)                 vphase_q <= V_FRONT;
                V_FRONT: if (int'(y_next) == V_ACTIVE + V_FP)          vphase_q <= V_SYNCP;
                V_SYNCP: if (int'(y_next) == V_ACTIVE + V_FP + V_SYNC) vphase_q <= V_BACK;
                V_BACK:  if (y_next == 10'd0)                          vphase_q <= V_ACT;
                default:                                               vphase_q <= V_ACT;
            endcase
        end
    end

    assign vphase = vphase_q;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Count completed frames one cycle after frame_tick, wrapping naturally at 16 bits
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (frame_tick) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: one default-timing instance for line-level
// checks and one small-timing instance so whole frames stay short.
module tb_vga_sync_gen;

    // Small timing: H_TOTAL = 32, V_TOTAL = 20, frame = 640 cycles
    localparam int SH_A = 16, SH_F = 4, SH_S = 8, SH_B = 4;
    localparam int SV_A = 12, SV_F = 2, SV_S = 2, SV_B = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic [9:0]  d_x, d_y, s_x, s_y;
    logic        d_hs, d_vs, d_da, d_lt, d_ft;
    logic        s_hs, s_vs, s_da, s_lt, s_ft;
    logic [1:0]  d_vp, s_vp;
    logic [15:0] d_fc, s_fc;

    vga_sync_gen dut (
        .VGA_clk     (clk),
        .reset       (reset),
        .xCount      (d_x),
        .yCount      (d_y),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .displayArea (d_da),
        .line_tick   (d_lt),
        .frame_tick  (d_ft),
        .vphase      (d_vp),
        .frame_count (d_fc)
    );

    vga_sync_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B)
    ) dut_s (
        .VGA_clk     (clk),
        .reset       (reset),
        .xCount      (s_x),
        .yCount      (s_y),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .displayArea (s_da),
        .line_tick   (s_lt),
        .frame_tick  (s_ft),
        .vphase      (s_vp),
        .frame_count (s_fc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] pack(input logic [9:0] x, input logic [9:0] y,
                                         input logic hs, input logic vs, input logic da,
                                         input logic lt, input logic ft,
                                         input logic [1:0] vp, input logic [15:0] fc);
        return {21'd0, fc, x, y, hs, vs, da, lt, ft, vp};
    endfunction

    function automatic logic [63:0] obs_d();
        return pack(d_x, d_y, d_hs, d_vs, d_da, d_lt, d_ft, d_vp, d_fc);
    endfunction

    function automatic logic [63:0] obs_s();
        return pack(s_x, s_y, s_hs, s_vs, s_da, s_lt, s_ft, s_vp, s_fc);
    endfunction

    // Expected outputs c clock edges after reset release (c = 0 is the reset state)
    function automatic logic [63:0] exp_at(input int c,
                                           input int ha, input int hf, input int hs, input int hb,
                                           input int va, input int vf, input int vs, input int vb);
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int fr = ht * vt;
        int pos = c % fr;
        int x = pos % ht;
        int y = pos / ht;
        logic [1:0] vp;
        int fc = 0;
        if (y < va)                vp = 2'd0;
        else if (y < va + vf)      vp = 2'd1;
        else if (y < va + vf + vs) vp = 2'd2;
        else                       vp = 2'd3;
`ifdef VGA_FRAME_CNT_EN
        if (c - 1 >= va * ht) fc = (c - 1 - va * ht) / fr + 1;
`endif
        return pack(10'(x), 10'(y),
                    !((x >= ha + hf) && (x < ha + hf + hs)),
                    !((y >= va + vf) && (y < va + vf + vs)),
                    (x < ha) && (y < va),
                    x == ht - 1,
                    (x == 0) && (y == va),
                    vp, 16'(fc));
    endfunction

    function automatic logic [63:0] exp_d(input int c);
        return exp_at(c, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [63:0] exp_s(input int c);
        return exp_at(c, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B);
    endfunction

    initial begin
        logic [63:0] rst_val;
        int hs_low, lt_n, da_n, vs_low, ft_n, n_tr;
        logic [1:0] prev_vp;
        logic [1:0] tr_vp [8];
        logic [9:0] tr_y  [8];
        logic [1:0] want_vp [4];
        logic [9:0] want_y  [4];

        rst_val = pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
        hs_low = 0; lt_n = 0; da_n = 0; vs_low = 0; ft_n = 0; n_tr = 0;
        want_vp = '{2'd1, 2'd2, 2'd3, 2'd0};
        want_y  = '{10'd12, 10'd14, 10'd16, 10'd0};

        // Reset state held across clock edges
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_def", obs_d(), rst_val);
        check("reset_small", obs_s(), rst_val);

        reset = 1'b0;
        prev_vp = s_vp;

        // Free run: one line at default timing, three small frames plus a partial one
        for (int c = 1; c <= 2154; c++) begin
            @(negedge clk);
            check("pos_def", obs_d(), exp_d(c));
            check("pos_small", obs_s(), exp_s(c));
            if (c == 1)   check("first_edge", {d_x, d_y}, {10'd1, 10'd0});
            if (c == 799) check("x_last", {d_x, d_y}, {10'd799, 10'd0});
            if (c == 800) check("x_wrap_y_inc", {d_x, d_y}, {10'd0, 10'd1});
            if (c == 640) check("xy_wrap_small", {s_x, s_y, s_vp, s_da}, {10'd0, 10'd0, 2'd0, 1'b1});
            if (c <= 800) begin
                if (!d_hs) hs_low++;
                if (d_lt)  lt_n++;
            end
            if (c <= 640) begin
                if (s_da)  da_n++;
                if (!s_vs) vs_low++;
                if (s_vp != prev_vp && n_tr < 8) begin
                    tr_vp[n_tr] = s_vp;
                    tr_y[n_tr]  = s_y;
                    n_tr++;
                end
                prev_vp = s_vp;
            end
            if (c <= 1920 && s_ft) ft_n++;
        end

        check("hsync_low_cycles", 64'(hs_low), 64'd96);
        check("line_tick_count", 64'(lt_n), 64'd1);
        check("display_cycles", 64'(da_n), 64'(SH_A * SV_A));
        check("vsync_low_cycles", 64'(vs_low), 64'(SV_S * 32));
        check("frame_tick_3frames", 64'(ft_n), 64'd3);
        check("vphase_transitions", 64'(n_tr), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < n_tr) check("vphase_seq", {tr_vp[i], tr_y[i]}, {want_vp[i], want_y[i]});
        end

        // Asynchronous reset mid-line / mid-frame, between clock edges
        check("pre_reset_pos", {s_x, s_y, d_x, d_y}, {10'd10, 10'd7, 10'd554, 10'd2});
        reset = 1'b1;
        #1;
        check("async_reset_def", obs_d(), rst_val);
        check("async_reset_small", obs_s(), rst_val);
        @(posedge clk);
        @(negedge clk);
        check("reset_hold_def", obs_d(), rst_val);
        reset = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            check("post_reset_def", obs_d(), exp_d(c));
            check("post_reset_small", obs_s(), exp_s(c));
        end

`ifdef VGA_FRAME_CNT_EN
        // Preloaded counter must wrap to zero after the next frame_tick
        begin
            logic seen;
            seen = 1'b0;
            force dut_s.frame_cnt_q = 16'hFFFF;
            for (int k = 0; k < 1000 && !seen; k++) begin
                @(negedge clk);
                if (s_ft) seen = 1'b1;
            end
            check("frame_tick_seen", 64'(seen), 64'd1);
            release dut_s.frame_cnt_q;
            @(negedge clk);
            check("frame_count_wrap", 64'(s_fc), 64'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
